// File: rtl/julia_pixel_dispatcher_if.sv
// ---------------------------------------------------------------------------
// julia_pixel_dispatcher_if
//
// Groups the two streaming connections of the Julia pixel dispatcher:
//   - engine side : calc_start / calc_done handshake, starting z, latched c,
//                   starting iteration count and the 8-bit pixel result
//   - pixel side  : valid/ready stream of {pix_last, pix_data} toward the
//                   frame buffer / bus master
//
// Modports:
//   master : the dispatcher (drives calc_start, z/c/iteration, pix_valid/data/last)
//   slave  : engine + downstream consumer (drives calc_done, pixel_in, pix_ready)
// ---------------------------------------------------------------------------
interface julia_pixel_dispatcher_if #(
    parameter int WIDTH = 22
) ();

    // Engine handshake
    logic             calc_start;
    logic [WIDTH-1:0] z_real_out;
    logic [WIDTH-1:0] z_imag_out;
    logic [WIDTH-1:0] c_real_out;
    logic [WIDTH-1:0] c_imag_out;
    logic [7:0]       iteration_out;
    logic             calc_done;
    logic [7:0]       pixel_in;

    // Pixel output stream
    logic             pix_valid;
    logic [7:0]       pix_data;
    logic             pix_last;
    logic             pix_ready;

    modport master (
        output calc_start, z_real_out, z_imag_out, c_real_out, c_imag_out, iteration_out,
        input  calc_done, pixel_in,
        output pix_valid, pix_data, pix_last,
        input  pix_ready
    );

    modport slave (
        input  calc_start, z_real_out, z_imag_out, c_real_out, c_imag_out, iteration_out,
        output calc_done, pixel_in,
        input  pix_valid, pix_data, pix_last,
        output pix_ready
    );

endinterface

// File: rtl/julia_pixel_dispatcher.sv
// ---------------------------------------------------------------------------
// julia_pixel_dispatcher
//
// Scans a (cols+1) x (rows+1) tile in raster order, hands each pixel's
// starting z to the Julia engine through calc_start/calc_done, captures the
// 8-bit result and queues {last, pixel} in a small valid/ready FIFO.
//
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   frame_start          pulse; latches tile config and starts a scan (IDLE only)
//   x_origin, y_origin   coordinate of column 0 / row 0 (top row)
//   step                 coordinate increment per pixel (both axes)
//   cols, rows           tile width-1 / height-1
//   c_real_in, c_imag_in Julia constant, latched at frame_start
//   eng                  julia_pixel_dispatcher_if.master (engine + pixel stream)
//   busy                 high from frame_start accept until DONE
//   frame_done           one-cycle pulse after the last pixel entered the FIFO
//   timeout_flag         (watchdog build only) sticky engine-timeout indicator
//
// Optional feature: define JULIA_DISPATCH_WATCHDOG_EN to abort a WAIT that
// lasts 300 cycles, substituting pixel 8'hFF and raising timeout_flag.
// ---------------------------------------------------------------------------
module julia_pixel_dispatcher #(
    parameter int WIDTH      = 22,
    parameter int FRACTIONAL = 11,
    parameter int DIM_BITS   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 frame_start,
    input  logic [WIDTH-1:0]     x_origin,
    input  logic [WIDTH-1:0]     y_origin,
    input  logic [WIDTH-1:0]     step,
    input  logic [DIM_BITS-1:0]  cols,
    input  logic [DIM_BITS-1:0]  rows,
    input  logic [WIDTH-1:0]     c_real_in,
    input  logic [WIDTH-1:0]     c_imag_in,
    julia_pixel_dispatcher_if.master eng,
    output logic                 busy,
    output logic                 frame_done
`ifdef JULIA_DISPATCH_WATCHDOG_EN
    ,
    output logic                 timeout_flag
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Coordinates are plain two's-complement add/sub, so the binary point only
    // has to leave at least one integer bit.
    if (FRACTIONAL >= WIDTH || FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_params
        $error("julia_pixel_dispatcher: illegal FRACTIONAL/WIDTH/FIFO_DEPTH combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUSH,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]    x_origin_q, step_q, c_real_q, c_imag_q;
    logic [WIDTH-1:0]    z_real_q, z_imag_q;
    logic [DIM_BITS-1:0] cols_q, rows_q, col_q, row_q;
    logic [7:0]          hold_q;
    logic                hold_last_q;

    logic [8:0]          fifo_mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic [8:0]          fifo_head;
    logic                fifo_full, fifo_empty, fifo_pop;

    logic                start_accept, capture, push_fire, at_last, wd_expire;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];
    assign fifo_pop   = !fifo_empty && eng.pix_ready;

    assign start_accept = (state_q == S_IDLE) && frame_start;
    // calc_done is only trusted in WAIT: during ISSUE the engine is still loading.
    assign capture      = (state_q == S_WAIT) && (eng.calc_done || wd_expire);
    assign push_fire    = (state_q == S_PUSH) && !fifo_full;
    assign at_last      = (col_q == cols_q) && (row_q == rows_q);

`ifdef JULIA_DISPATCH_WATCHDOG_EN
    localparam logic [8:0] WD_LIMIT = 9'd299;

    logic [8:0] wd_cnt_q;
    logic       timeout_q;

    // Expires on the 300th consecutive WAIT cycle.
    assign wd_expire    = (state_q == S_WAIT) && (wd_cnt_q == WD_LIMIT);
    assign timeout_flag = timeout_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q <= (state_q == S_WAIT) ? wd_cnt_q + 9'd1 : '0;
            if (start_accept)
                timeout_q <= 1'b0;
            else if (wd_expire && !eng.calc_done)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (frame_start) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (capture) state_d = S_PUSH;
            S_PUSH:  if (!fifo_full) state_d = hold_last_q ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            x_origin_q  <= '0;
            step_q      <= '0;
            c_real_q    <= '0;
            c_imag_q    <= '0;
            z_real_q    <= '0;
            z_imag_q    <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q <= state_d;

            if (start_accept) begin
                x_origin_q <= x_origin;
                step_q     <= step;
                c_real_q   <= c_real_in;
                c_imag_q   <= c_imag_in;
                cols_q     <= cols;
                rows_q     <= rows;
                z_real_q   <= x_origin;
                z_imag_q   <= y_origin;
                col_q      <= '0;
                row_q      <= '0;
            end

            if (capture) begin
                hold_q      <= eng.calc_done ? eng.pixel_in : 8'hFF;
                hold_last_q <= at_last;
            end

            // Raster advance: rows move toward negative imaginary (top row first).
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                if (col_q < cols_q) begin
                    col_q    <= col_q + DIM_BITS'(1);
                    z_real_q <= z_real_q + step_q;
                end else begin
                    col_q    <= '0;
                    z_real_q <= x_origin_q;
                    row_q    <= row_q + DIM_BITS'(1);
                    z_imag_q <= z_imag_q - step_q;
                end
            end

            if (fifo_pop)
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries
    // are meaningful, and the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_fire)
            fifo_mem[wr_ptr_q[AW-1:0]] <= {hold_last_q, hold_q};
    end

    assign eng.calc_start    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign eng.z_real_out    = z_real_q;
    assign eng.z_imag_out    = z_imag_q;
    assign eng.c_real_out    = c_real_q;
    assign eng.c_imag_out    = c_imag_q;
    assign eng.iteration_out = 8'd0;

    assign eng.pix_valid = !fifo_empty;
    assign eng.pix_data  = fifo_empty ? 8'd0 : fifo_head[7:0];
    assign eng.pix_last  = fifo_empty ? 1'b0 : fifo_head[8];

    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_PUSH);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_julia_pixel_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_julia_pixel_dispatcher
//
// Scoreboard bench: each frame is expanded up front into the list of starting
// z values the engine must see and the {last, pixel} words the output stream
// must deliver. An engine model checks z/c at every calculation start and
// returns the planned pixel; a monitor pops the expected stream on every
// accepted output beat.
// ---------------------------------------------------------------------------
module tb_julia_pixel_dispatcher;

    localparam int WIDTH      = 22;
    localparam int DIM_BITS   = 10;
    localparam int FIFO_DEPTH = 2;

    typedef struct {
        logic [WIDTH-1:0] zr;
        logic [WIDTH-1:0] zi;
    } zexp_t;

    logic                clk = 1'b0;
    logic                n_rst = 1'b0;
    logic                frame_start = 1'b0;
    logic [WIDTH-1:0]    x_origin = '0, y_origin = '0, step = '0;
    logic [DIM_BITS-1:0] cols = '0, rows = '0;
    logic [WIDTH-1:0]    c_real_in = '0, c_imag_in = '0;
    logic                busy, frame_done;
`ifdef JULIA_DISPATCH_WATCHDOG_EN
    logic                timeout_flag;
`endif

    logic       eng_done = 1'b0;
    logic [7:0] eng_pixel = 8'd0;
    logic       pix_ready_r = 1'b0;

    julia_pixel_dispatcher_if #(.WIDTH(WIDTH)) bus ();

    // Engine contract: calc_done reads 1 whenever calc_start is low.
    assign bus.calc_done = !bus.calc_start || eng_done;
    assign bus.pixel_in  = eng_pixel;
    assign bus.pix_ready = pix_ready_r;

    julia_pixel_dispatcher #(
        .WIDTH(WIDTH), .FRACTIONAL(11), .DIM_BITS(DIM_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
        .x_origin(x_origin), .y_origin(y_origin), .step(step),
        .cols(cols), .rows(rows), .c_real_in(c_real_in), .c_imag_in(c_imag_in),
        .eng(bus), .busy(busy), .frame_done(frame_done)
`ifdef JULIA_DISPATCH_WATCHDOG_EN
        , .timeout_flag(timeout_flag)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    zexp_t      exp_z[$];
    logic [7:0] eng_pix_q[$];
    logic [8:0] exp_out[$];
    logic [WIDTH-1:0] cr_exp = '0, ci_exp = '0;

    int eng_lat    = 3;
    bit eng_glitch = 1'b0;
    bit eng_hang   = 1'b0;
    int ready_mode = 0;     // 0: always ready, 1: random, 2: never ready
    int start_count = 0;
    int fd_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Engine model: sampled #1 after each rising edge.
    initial begin
        int cnt;
        logic [7:0] val;
        zexp_t ez;
        cnt = 0;
        val = 8'd0;
        ez  = '{zr: '0, zi: '0};
        forever begin
            @(posedge clk);
            #1;
            if (!bus.calc_start) begin
                cnt = 0;
                eng_done = 1'b0;
            end else begin
                cnt++;
                if (cnt == 1) begin
                    start_count++;
                    if (exp_z.size() == 0) begin
                        fail("unexpected_calc_start");
                    end else begin
                        ez = exp_z.pop_front();
                        check("z_real_at_start", bus.z_real_out, ez.zr);
                        check("z_imag_at_start", bus.z_imag_out, ez.zi);
                        check("c_real", bus.c_real_out, cr_exp);
                        check("c_imag", bus.c_imag_out, ci_exp);
                        check("iteration", bus.iteration_out, 8'd0);
                    end
                    val = (eng_pix_q.size() != 0) ? eng_pix_q.pop_front() : 8'd0;
                    if (eng_glitch) begin
                        eng_done  = 1'b1;   // asserted during ISSUE with a bogus value
                        eng_pixel = 8'hEE;
                    end
                end else if (cnt == 2 && eng_glitch) begin
                    eng_done = 1'b0;
                end
                if (!eng_hang && cnt == eng_lat) begin
                    check("z_real_stable", bus.z_real_out, ez.zr);
                    check("z_imag_stable", bus.z_imag_out, ez.zi);
                    eng_done  = 1'b1;
                    eng_pixel = val;
                end
            end
        end
    end

    // Downstream ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_ready_r = 1'b1;
                1:       pix_ready_r = 1'($urandom_range(0, 1));
                default: pix_ready_r = 1'b0;
            endcase
        end
    end

    // Output monitor: sampled on the falling edge.
    initial begin
        logic       prev_stall;
        logic [8:0] prev_head;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_head  = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", bus.pix_valid, 1'b1);
                    check("stall_head_held", {bus.pix_last, bus.pix_data}, prev_head);
                end
                if (bus.pix_valid && bus.pix_ready) begin
                    if (exp_out.size() == 0) begin
                        fail("unexpected_pixel_beat");
                    end else begin
                        e = exp_out.pop_front();
                        check("pix_data", bus.pix_data, e[7:0]);
                        check("pix_last", bus.pix_last, e[8]);
                    end
                end
                prev_stall = bus.pix_valid && !bus.pix_ready;
                prev_head  = {bus.pix_last, bus.pix_data};
                if (frame_done) fd_count++;
            end
        end
    end

    // Reference expansion of a tile: z by direct multiplication from the origin.
    task automatic build_frame(input logic [WIDTH-1:0] xo, input logic [WIDTH-1:0] yo,
                               input logic [WIDTH-1:0] st, input int nc, input int nr,
                               input logic [WIDTH-1:0] cr, input logic [WIDTH-1:0] ci,
                               input bit plan_pix);
        zexp_t      z;
        logic [7:0] pix;
        logic       last;
        cr_exp = cr;
        ci_exp = ci;
        for (int r = 0; r <= nr; r++) begin
            for (int c = 0; c <= nc; c++) begin
                z.zr = xo + st * WIDTH'(c);
                z.zi = yo - st * WIDTH'(r);
                exp_z.push_back(z);
                pix  = plan_pix ? 8'(c + 2 * r) : 8'($urandom);
                last = (r == nr) && (c == nc);
                eng_pix_q.push_back(pix);
                exp_out.push_back({last, eng_hang ? 8'hFF : pix});
            end
        end
    endtask

    task automatic drive_start(input logic [WIDTH-1:0] xo, input logic [WIDTH-1:0] yo,
                               input logic [WIDTH-1:0] st, input int nc, input int nr,
                               input logic [WIDTH-1:0] cr, input logic [WIDTH-1:0] ci);
        @(posedge clk);
        #1;
        x_origin    = xo;
        y_origin    = yo;
        step        = st;
        cols        = DIM_BITS'(nc);
        rows        = DIM_BITS'(nr);
        c_real_in   = cr;
        c_imag_in   = ci;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_out.size() == 0 && !busy && !bus.pix_valid) && n < budget);
        if (n >= budget) fail("frame_timeout");
        check("z_queue_drained", exp_z.size(), 0);
    endtask

    task automatic do_frame(input logic [WIDTH-1:0] xo, input logic [WIDTH-1:0] yo,
                            input logic [WIDTH-1:0] st, input int nc, input int nr,
                            input bit plan_pix, input bit poke_busy);
        logic [WIDTH-1:0] cr, ci;
        int fd0;
        cr  = WIDTH'($urandom);
        ci  = WIDTH'($urandom);
        fd0 = fd_count;
        build_frame(xo, yo, st, nc, nr, cr, ci, plan_pix);
        drive_start(xo, yo, st, nc, nr, cr, ci);
        check("busy_after_start", busy, 1'b1);
        if (poke_busy) begin
            repeat (3) @(posedge clk);
            drive_start(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 7, 7,
                        WIDTH'($urandom), WIDTH'($urandom));
        end
        wait_frame(4000);
        check("frame_done_pulses", fd_count - fd0, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_calc_start", bus.calc_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_pix_valid", bus.pix_valid, 1'b0);
        check("rst_pix_head", {bus.pix_last, bus.pix_data}, 9'd0);
        check("rst_z_real", bus.z_real_out, '0);
        check("rst_c_imag", bus.c_imag_out, '0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // 2x2 planned tile: pixels col+2*row, always ready
        ready_mode = 0;
        eng_lat    = 3;
        do_frame(WIDTH'(-2048), WIDTH'(2048), WIDTH'(1024), 1, 1, 1'b1, 1'b0);

        // Engine raises calc_done during ISSUE with a bogus value
        eng_glitch = 1'b1;
        eng_lat    = 4;
        do_frame(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 2, 1, 1'b0, 1'b0);
        eng_glitch = 1'b0;

        // 3x1 tile with no downstream ready: FIFO fills and the dispatcher stalls
        begin
            int s0, fd0;
            logic [WIDTH-1:0] cr, ci;
            ready_mode = 2;
            eng_lat    = 3;
            s0  = start_count;
            fd0 = fd_count;
            cr  = WIDTH'($urandom);
            ci  = WIDTH'($urandom);
            build_frame(WIDTH'(100), WIDTH'(-100), WIDTH'(7), 2, 0, cr, ci, 1'b0);
            drive_start(WIDTH'(100), WIDTH'(-100), WIDTH'(7), 2, 0, cr, ci);
            repeat (60) @(negedge clk);
            check("stall_calc_start_low", bus.calc_start, 1'b0);
            check("stall_busy", busy, 1'b1);
            check("stall_pix_valid", bus.pix_valid, 1'b1);
            check("stall_starts_issued", start_count - s0, 3);
            check("stall_outputs_pending", exp_out.size(), 3);
            ready_mode = 0;
            wait_frame(500);
            check("stall_frame_done_pulses", fd_count - fd0, 1);
        end

        // Wrap: x_origin = 2^21-1, step 1, two columns
        do_frame(WIDTH'(22'h1FFFFF), WIDTH'(5), WIDTH'(1), 1, 0, 1'b0, 1'b0);

        // Single-pixel tile, with a frame_start poke that must be ignored
        do_frame(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 0, 0, 1'b0, 1'b0);
        eng_lat = 6;
        do_frame(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 2, 2, 1'b0, 1'b1);

        // Reset while waiting on pixel (1,0)
        begin
            int s0, n;
            logic [WIDTH-1:0] cr, ci;
            eng_lat = 20;
            s0 = start_count;
            cr = WIDTH'($urandom);
            ci = WIDTH'($urandom);
            build_frame(WIDTH'(300), WIDTH'(400), WIDTH'(10), 2, 0, cr, ci, 1'b0);
            drive_start(WIDTH'(300), WIDTH'(400), WIDTH'(10), 2, 0, cr, ci);
            n = 0;
            while (start_count - s0 < 2 && n < 200) begin
                @(posedge clk);
                n++;
            end
            if (n >= 200) fail("reset_test_second_pixel_timeout");
            repeat (3) @(posedge clk);
            #1;
            n_rst = 1'b0;
            #1;
            check("abort_calc_start", bus.calc_start, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_pix_valid", bus.pix_valid, 1'b0);
            exp_z.delete();
            eng_pix_q.delete();
            exp_out.delete();
            repeat (2) @(posedge clk);
            #1;
            n_rst = 1'b1;
            eng_lat = 3;
            do_frame(WIDTH'(-5), WIDTH'(9), WIDTH'(3), 1, 1, 1'b1, 1'b0);
        end

        // Randomized tiles with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 5; i++) begin
            eng_lat    = $urandom_range(3, 6);
            eng_glitch = 1'($urandom_range(0, 1));
            do_frame(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b0);
        end
        eng_glitch = 1'b0;
        ready_mode = 0;

`ifdef JULIA_DISPATCH_WATCHDOG_EN
        // Engine never completes: watchdog substitutes 8'hFF
        eng_hang = 1'b1;
        do_frame(WIDTH'(1), WIDTH'(2), WIDTH'(3), 0, 0, 1'b0, 1'b0);
        check("timeout_flag_set", timeout_flag, 1'b1);
        eng_hang = 1'b0;
        begin
            logic [WIDTH-1:0] cr, ci;
            cr = WIDTH'($urandom);
            ci = WIDTH'($urandom);
            build_frame(WIDTH'(4), WIDTH'(5), WIDTH'(6), 0, 0, cr, ci, 1'b0);
            drive_start(WIDTH'(4), WIDTH'(5), WIDTH'(6), 0, 0, cr, ci);
            check("timeout_flag_cleared", timeout_flag, 1'b0);
            wait_frame(500);
        end
`endif

        repeat (5) @(negedge clk);
        check("leftover_outputs", exp_out.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
